// File: rtl/sseg_scan_driver.sv
// Multiplexed 4-digit common-anode seven-segment driver. Scans one digit per
// slot from a per-frame snapshot of the BCD bus, with blanking, dp and anode guard.
module sseg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic        display_on,
    input  logic        blank_lz,
    input  logic        dp_en,
    input  logic [1:0]  dp_pos,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int            PW      = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_GUARD = PW'(GUARD);

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b0111111;
        endcase
        return pat;
    endfunction

    logic [PW-1:0] p_p0;
    logic [1:0]    s_p0;
    logic [15:0]   snap_p0;
    logic          slot_end;

    assign slot_end = (p_p0 == P_LAST);

    // Stage p0: prescaler, slot counter and frame snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            p_p0    <= '0;
            s_p0    <= 2'd0;
            snap_p0 <= 16'h0000;
        end else begin
            p_p0 <= slot_end ? '0 : p_p0 + 1'b1;
            if (slot_end) begin
                s_p0 <= s_p0 + 2'd1;
                if (s_p0 == 2'd3)
                    snap_p0 <= digits;
            end
        end
    end

    assign frame_tick = (s_p0 == 2'd0) && (p_p0 == '0);

    logic [3:0] blank;
    logic [3:0] cur_digit;
    logic [3:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    // Blanking chains from the most significant digit down; d0 always shows.
    always_comb begin
        blank[3]  = blank_lz && (snap_p0[15:12] == 4'd0);
        blank[2]  = blank[3] && (snap_p0[11:8] == 4'd0);
        blank[1]  = blank[2] && (snap_p0[7:4] == 4'd0);
        blank[0]  = 1'b0;
        cur_digit = snap_p0[{s_p0, 2'b00} +: 4];
        an_nxt    = 4'b1111;
        if (display_on && (p_p0 >= P_GUARD))
            an_nxt[s_p0] = 1'b0;
        seg_nxt   = blank[s_p0] ? 7'b1111111 : seg_decode(cur_digit);
        dp_nxt    = !(dp_en && (dp_pos == s_p0) && display_on);
    end

    logic [3:0] an_p1;
    logic [6:0] seg_p1;
    logic       dp_p1;

    // Stage p1: registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            an_p1  <= 4'b1111;
            seg_p1 <= 7'b1111111;
            dp_p1  <= 1'b1;
        end else begin
            an_p1  <= an_nxt;
            seg_p1 <= seg_nxt;
            dp_p1  <= dp_nxt;
        end
    end

    assign an  = an_p1;
    assign seg = seg_p1;
    assign dp  = dp_p1;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: cycle scoreboard from a behavioural display model
// plus directed checks of the reset, tear-free, blanking, dp and display-off cases.
module tb_sseg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic        display_on;
    logic        blank_lz;
    logic        dp_en;
    logic [1:0]  dp_pos;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    sseg_scan_driver #(.REFRESH_DIV(8), .GUARD(2)) dut (
        .clk(clk), .reset(reset), .digits(digits), .display_on(display_on),
        .blank_lz(blank_lz), .dp_en(dp_en), .dp_pos(dp_pos),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_pattern(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected {an,seg,dp} for one slot cycle of the model state.
    function automatic logic [11:0] model_out(input logic [1:0] s, input logic [2:0] p,
                                              input logic [15:0] snap, input logic on,
                                              input logic bl, input logic den,
                                              input logic [1:0] dpos);
        logic       blk;
        logic [3:0] a;
        logic [6:0] sg;
        logic       d;
        blk = bl && (s != 2'd0);
        for (int k = 0; k < 4; k++)
            if (k >= int'(s) && snap[k*4 +: 4] != 4'd0) blk = 1'b0;
        sg = blk ? 7'b1111111 : ref_pattern(snap[int'(s)*4 +: 4]);
        a  = (on && p >= 3'd2) ? ~(4'b0001 << s) : 4'b1111;
        d  = !(den && dpos == s && on);
        return {a, sg, d};
    endfunction

    logic [2:0]  m_p;
    logic [1:0]  m_s;
    logic [15:0] m_snap;
    logic [11:0] exp_q[$];

    always @(posedge clk) begin
        if (reset) begin
            exp_q.push_back(12'hFFF);
            m_p    <= 3'd0;
            m_s    <= 2'd0;
            m_snap <= 16'h0000;
        end else begin
            exp_q.push_back(model_out(m_s, m_p, m_snap, display_on, blank_lz, dp_en, dp_pos));
            if (m_p == 3'd7) begin
                m_p <= 3'd0;
                m_s <= m_s + 2'd1;
                if (m_s == 2'd3) m_snap <= digits;
            end else begin
                m_p <= m_p + 3'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            chk("sb_out", {an, seg, dp}, exp_q.pop_front());
            chk("sb_tick", frame_tick, (m_s == 2'd0 && m_p == 3'd0));
        end
    end

    task automatic wait_state(input string tag, input logic [1:0] s, input logic [2:0] p);
        for (int k = 0; k < 200; k++) begin
            if (m_s == s && m_p == p) break;
            @(negedge clk);
        end
        chk({tag, "_reach"}, {m_s, m_p}, {s, p});
    endtask

    // Outputs of state (s,p) appear one cycle after that state is current.
    task automatic expect_at(input string tag, input logic [1:0] s, input logic [2:0] p,
                             input logic [11:0] e);
        wait_state(tag, s, p);
        @(negedge clk);
        chk(tag, {an, seg, dp}, e);
    endtask

    initial begin
        reset      = 1'b1;
        digits     = 16'h1234;
        display_on = 1'b1;
        blank_lz   = 1'b0;
        dp_en      = 1'b0;
        dp_pos     = 2'd0;

        @(negedge clk);
        chk("rst_out", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("tick_release", frame_tick, 1'b1);

        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1)  chk("tick_low", frame_tick, 1'b0);
            if (i == 30) chk("frame0_d3", {an, seg, dp}, {4'b0111, 7'b1000000, 1'b1});
            if (i == 32) chk("tick_32", frame_tick, 1'b1);
            if (i >= 33)
                chk("frame1_d0", {an, seg, dp}, {(i >= 35) ? 4'b1110 : 4'b1111, 7'b0011001, 1'b1});
        end

        digits = 16'h5678;
        expect_at("tear_d1", 2'd1, 3'd4, {4'b1101, 7'b0110000, 1'b1});
        expect_at("tear_d2", 2'd2, 3'd4, {4'b1011, 7'b0100100, 1'b1});
        expect_at("tear_d3", 2'd3, 3'd4, {4'b0111, 7'b1111001, 1'b1});
        expect_at("new_d0",  2'd0, 3'd4, {4'b1110, 7'b0000000, 1'b1});
        expect_at("new_d1",  2'd1, 3'd4, {4'b1101, 7'b1111000, 1'b1});
        expect_at("new_d2",  2'd2, 3'd4, {4'b1011, 7'b0000010, 1'b1});
        expect_at("new_d3",  2'd3, 3'd4, {4'b0111, 7'b0010010, 1'b1});

        digits   = 16'h0050;
        blank_lz = 1'b1;
        expect_at("lz50_d0", 2'd0, 3'd4, {4'b1110, 7'b1000000, 1'b1});
        expect_at("lz50_d1", 2'd1, 3'd4, {4'b1101, 7'b0010010, 1'b1});
        expect_at("lz50_d2", 2'd2, 3'd4, {4'b1011, 7'b1111111, 1'b1});
        expect_at("lz50_d3", 2'd3, 3'd4, {4'b0111, 7'b1111111, 1'b1});

        digits = 16'h0000;
        expect_at("lz0_d0", 2'd0, 3'd4, {4'b1110, 7'b1000000, 1'b1});
        expect_at("lz0_d1", 2'd1, 3'd4, {4'b1101, 7'b1111111, 1'b1});
        expect_at("lz0_d2", 2'd2, 3'd4, {4'b1011, 7'b1111111, 1'b1});
        expect_at("lz0_d3", 2'd3, 3'd4, {4'b0111, 7'b1111111, 1'b1});

        blank_lz = 1'b0;
        expect_at("nolz_d0", 2'd0, 3'd4, {4'b1110, 7'b1000000, 1'b1});
        expect_at("nolz_d1", 2'd1, 3'd4, {4'b1101, 7'b1000000, 1'b1});
        expect_at("nolz_d2", 2'd2, 3'd4, {4'b1011, 7'b1000000, 1'b1});
        expect_at("nolz_d3", 2'd3, 3'd4, {4'b0111, 7'b1000000, 1'b1});

        digits = 16'h00A9;
        expect_at("bad_d0", 2'd0, 3'd4, {4'b1110, 7'b0010000, 1'b1});
        expect_at("bad_d1", 2'd1, 3'd4, {4'b1101, 7'b0111111, 1'b1});
        expect_at("bad_d2", 2'd2, 3'd4, {4'b1011, 7'b1000000, 1'b1});

        dp_en  = 1'b1;
        dp_pos = 2'd2;
        expect_at("dp_s3",  2'd3, 3'd4, {4'b0111, 7'b1000000, 1'b1});
        expect_at("dp_s0",  2'd0, 3'd4, {4'b1110, 7'b0010000, 1'b1});
        expect_at("dp_s2g", 2'd2, 3'd0, {4'b1111, 7'b1000000, 1'b0});
        expect_at("dp_s2",  2'd2, 3'd4, {4'b1011, 7'b1000000, 1'b0});

        display_on = 1'b0;
        @(negedge clk);
        chk("off_next", {an, seg, dp}, {4'b1111, 7'b1000000, 1'b1});
        for (int k = 0; k < 40; k++) begin
            if (frame_tick) break;
            @(negedge clk);
        end
        chk("off_tick_find", frame_tick, 1'b1);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            chk("off_tick_period", frame_tick, (j == 32));
        end
        expect_at("off_s1", 2'd1, 3'd4, {4'b1111, 7'b0111111, 1'b1});

        display_on = 1'b1;
        wait_state("mid_rst", 2'd2, 3'd3);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_out", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        chk("mid_rst_tick", frame_tick, 1'b1);
        reset = 1'b0;
        expect_at("post_rst_d1", 2'd1, 3'd4, {4'b1101, 7'b1000000, 1'b1});
        expect_at("post_rst_d0", 2'd0, 3'd4, {4'b1110, 7'b0010000, 1'b1});
        expect_at("post_rst_d2", 2'd2, 3'd4, {4'b1011, 7'b1000000, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
